// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if -- bundle of every signal between mem_arbiter, its two
// requesters and the single-port memory.
//
// Modports:
//   master : arbiter view. Samples the requests and mem_rdata. Drives grants,
//            completion pulses, shared read data, the memory bus, and a debug
//            copy of the FSM state.
//   slave  : environment view (requesters plus memory). This is the mirror
//            image of master.
//
// Handshake: a requester raises reqN with we/addr/wdata valid. The arbiter
// captures them in the IDLE cycle in which gntN is seen high. doneN pulses for
// exactly one cycle when the access is complete. rdata is valid only during
// that pulse.
//
// Parameters: AW address width, DW data width.
// ---------------------------------------------------------------------------
interface mem_arbiter_if #(
   parameter int AW = 4,
   parameter int DW = 8
);
   // requester 0 (CPU)
   logic          req0;
   logic          we0;
   logic [AW-1:0] addr0;
   logic [DW-1:0] wdata0;
   // requester 1 (loader/debug)
   logic          req1;
   logic          we1;
   logic [AW-1:0] addr1;
   logic [DW-1:0] wdata1;
   // arbitration results
   logic          gnt0;
   logic          gnt1;
   logic          done0;
   logic          done1;
   logic [DW-1:0] rdata;
   // memory side
   logic [AW-1:0] mem_addr;
   logic          mem_read;
   logic          mem_write;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   // debug: current FSM state (0 IDLE, 1 ACCESS, 2 DONE)
   logic [1:0]    fsm_state;

   modport master (
      input  req0, we0, addr0, wdata0,
      input  req1, we1, addr1, wdata1,
      input  mem_rdata,
      output gnt0, gnt1, done0, done1, rdata,
      output mem_addr, mem_read, mem_write, mem_wdata,
      output fsm_state
   );

   modport slave (
      output req0, we0, addr0, wdata0,
      output req1, we1, addr1, wdata1,
      output mem_rdata,
      input  gnt0, gnt1, done0, done1, rdata,
      input  mem_addr, mem_read, mem_write, mem_wdata,
      input  fsm_state
   );
endinterface

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter -- two-requester arbiter in front of a single-port memory.
//
// A transaction takes three cycles: IDLE -> ACCESS -> DONE.
//   IDLE   : a winner is picked and its gnt is raised combinationally. Its
//            we/addr/wdata are captured on the clock edge.
//   ACCESS : mem_read or mem_write is high for one cycle. Read data is
//            captured on the closing edge.
//   DONE   : the owner's done pulses and its gnt stays high.
// Requests are looked at only in IDLE. A requester that keeps req high after
// its done pulse is treated as a fresh request in the next IDLE cycle.
//
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high. It clears all outputs and state at once.
//   bus   : mem_arbiter_if.master (requests, grants, memory bus, debug state)
//
// Configuration:
//   ARB_ROUND_ROBIN_EN defined   -> on a tie, the requester not granted last
//                                   wins. The pointer favours requester 0 after
//                                   reset.
//   ARB_ROUND_ROBIN_EN undefined -> fixed priority. Requester 0 wins every tie,
//                                   and there is no pointer state.
// ---------------------------------------------------------------------------
module mem_arbiter #(
   parameter int AW = 4,
   parameter int DW = 8
) (
   input logic           clk,
   input logic           reset,
   mem_arbiter_if.master bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t        state;
   logic          owner;        // requester that owns the current transaction
   logic          we_q;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] wdata_q;
   logic [DW-1:0] rdata_q;
   logic          mem_read_q;
   logic          mem_write_q;
   logic          done0_q;
   logic          done1_q;

   logic          any_req;
   logic          pick;         // 0 selects requester 0, 1 selects requester 1
   logic          sel_we;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_wdata;

   assign any_req = bus.req0 | bus.req1;

`ifdef ARB_ROUND_ROBIN_EN
   logic last;                  // requester granted most recently

   always_comb begin
      pick = bus.req1;
      if (bus.req0 && bus.req1) begin
         pick = ~last;
      end
   end
`else
   always_comb begin
      // Requester 1 wins only when requester 0 is silent.
      pick = bus.req1 & ~bus.req0;
   end
`endif

   always_comb begin
      sel_we    = bus.we0;
      sel_addr  = bus.addr0;
      sel_wdata = bus.wdata0;
      if (pick) begin
         sel_we    = bus.we1;
         sel_addr  = bus.addr1;
         sel_wdata = bus.wdata1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         owner       <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         done0_q     <= 1'b0;
         done1_q     <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
         // Pretend requester 1 went last so that requester 0 wins the first tie.
         last        <= 1'b1;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  owner       <= pick;
                  we_q        <= sel_we;
                  addr_q      <= sel_addr;
                  wdata_q     <= sel_wdata;
                  mem_read_q  <= ~sel_we;
                  mem_write_q <= sel_we;
                  state       <= ACCESS;
`ifdef ARB_ROUND_ROBIN_EN
                  last        <= pick;
`endif
               end
            end
            ACCESS: begin
               mem_read_q  <= 1'b0;
               mem_write_q <= 1'b0;
               // A write leaves the previous read data in place.
               if (!we_q) begin
                  rdata_q <= bus.mem_rdata;
               end
               done0_q <= ~owner;
               done1_q <= owner;
               state   <= DONE;
            end
            DONE: begin
               done0_q <= 1'b0;
               done1_q <= 1'b0;
               state   <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // In IDLE the grant follows the live pick. Gating with reset keeps the
   // grants low while reset is held, even if requests are present.
   always_comb begin
      bus.gnt0 = 1'b0;
      bus.gnt1 = 1'b0;
      if (!reset) begin
         if (state == IDLE) begin
            bus.gnt0 = any_req & ~pick;
            bus.gnt1 = any_req & pick;
         end else begin
            bus.gnt0 = ~owner;
            bus.gnt1 = owner;
         end
      end
   end

   assign bus.done0     = done0_q;
   assign bus.done1     = done1_q;
   assign bus.rdata     = rdata_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.mem_read  = mem_read_q;
   assign bus.mem_write = mem_write_q;
   assign bus.fsm_state = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter -- directed, table-driven bench for mem_arbiter.
// Each table row holds one clock cycle: the inputs applied just after a rising
// edge and the outputs expected at the following falling edge. A small memory
// model answers reads combinationally and performs writes on the rising edge.
// Its contents are reloaded while reset is high: mem[a] = 8'h20 + a, except
// mem[10] = 8'h02.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   mem_arbiter_if #(.AW(4), .DW(8)) bus ();

   mem_arbiter #(.AW(4), .DW(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // memory model
   logic [7:0] mem [16];

   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 16; i++) mem[i] <= 8'h20 + 8'(i);
         mem[10] <= 8'h02;
      end else if (bus.mem_write) begin
         mem[bus.mem_addr] <= bus.mem_wdata;
      end
   end

   assign bus.mem_rdata = mem[bus.mem_addr];

   // ctl = {gnt0, gnt1, done0, done1, mem_read, mem_write}
   typedef struct {
      logic       req0;
      logic       we0;
      logic [3:0] addr0;
      logic [7:0] wdata0;
      logic       req1;
      logic       we1;
      logic [3:0] addr1;
      logic [7:0] wdata1;
      logic [5:0] ctl;
      logic [3:0] maddr;
      logic [7:0] mwdata;
      logic [7:0] rdata;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(
      input logic r0, input logic w0, input logic [3:0] a0, input logic [7:0] d0,
      input logic r1, input logic w1, input logic [3:0] a1, input logic [7:0] d1,
      input logic [5:0] ctl, input logic [3:0] ma, input logic [7:0] md,
      input logic [7:0] rd);
      vec_t v;
      v.req0 = r0; v.we0 = w0; v.addr0 = a0; v.wdata0 = d0;
      v.req1 = r1; v.we1 = w1; v.addr1 = a1; v.wdata1 = d1;
      v.ctl = ctl; v.maddr = ma; v.mwdata = md; v.rdata = rd;
      return v;
   endfunction

   function automatic logic [5:0] ctl_now();
      return {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.mem_read, bus.mem_write};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic apply(input vec_t v);
      bus.req0 = v.req0; bus.we0 = v.we0; bus.addr0 = v.addr0; bus.wdata0 = v.wdata0;
      bus.req1 = v.req1; bus.we1 = v.we1; bus.addr1 = v.addr1; bus.wdata1 = v.wdata1;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // invariants checked on every falling edge outside reset
   always @(negedge clk) begin
      if (!reset) begin
         check("rd_wr_exclusive", {31'd0, bus.mem_read & bus.mem_write}, 32'd0);
         check("one_gnt", {31'd0, bus.gnt0 & bus.gnt1}, 32'd0);
         check("one_done", {31'd0, bus.done0 & bus.done1}, 32'd0);
      end
   end

   initial begin
      logic       w;
      logic [3:0] pa;
      logic [7:0] pd;
      logic [7:0] pr;
      logic [3:0] aw;
      logic [7:0] rw;
      vec_t       v;

      checks = 0;
      errors = 0;
      reset  = 1'b1;
      apply(mk(0,0,4'h0,8'h00, 0,0,4'h0,8'h00, 6'b0, 4'h0, 8'h00, 8'h00));

      // ---- vector table ----
      // read of addr A by requester 0 (addr0 changed mid-transaction)
      vecs.push_back(mk(0,0,4'h0,8'h00, 0,0,4'h0,8'h00, 6'b000000, 4'h0, 8'h00, 8'h00));
      vecs.push_back(mk(1,0,4'hA,8'h00, 0,0,4'h0,8'h00, 6'b100000, 4'h0, 8'h00, 8'h00));
      vecs.push_back(mk(1,0,4'h1,8'h00, 0,0,4'h0,8'h00, 6'b100010, 4'hA, 8'h00, 8'h00));
      vecs.push_back(mk(1,0,4'h1,8'h00, 0,0,4'h0,8'h00, 6'b101000, 4'hA, 8'h00, 8'h02));
      vecs.push_back(mk(0,0,4'h1,8'h00, 0,0,4'h0,8'h00, 6'b000000, 4'hA, 8'h00, 8'h02));
      // write 5A to addr 3 by requester 1, req1 dropped during ACCESS
      vecs.push_back(mk(0,0,4'h1,8'h00, 1,1,4'h3,8'h5A, 6'b010000, 4'hA, 8'h00, 8'h02));
      vecs.push_back(mk(0,0,4'h1,8'h00, 0,1,4'h3,8'h5A, 6'b010001, 4'h3, 8'h5A, 8'h02));
      vecs.push_back(mk(0,0,4'h1,8'h00, 0,1,4'h3,8'h5A, 6'b010100, 4'h3, 8'h5A, 8'h02));
      // read back addr 3 by requester 0, req0 dropped during ACCESS
      vecs.push_back(mk(1,0,4'h3,8'hC3, 0,0,4'h3,8'h5A, 6'b100000, 4'h3, 8'h5A, 8'h02));
      vecs.push_back(mk(0,0,4'h3,8'hC3, 0,0,4'h3,8'h5A, 6'b100010, 4'h3, 8'hC3, 8'h02));
      vecs.push_back(mk(0,0,4'h3,8'hC3, 0,0,4'h3,8'h5A, 6'b101000, 4'h3, 8'hC3, 8'h5A));
      vecs.push_back(mk(0,0,4'h3,8'hC3, 0,0,4'h3,8'h5A, 6'b000000, 4'h3, 8'hC3, 8'h5A));
      // Both requesters held high: read addr 7 (27) and addr 5 (25).
      // Round robin: requester 0 went last, so the winners run 1,0,1,0.
      // Fixed priority: the winner is always 0.
      pa = 4'h3; pd = 8'hC3; pr = 8'h5A;
      for (int k = 0; k < 4; k++) begin
         w  = RR ? ((k % 2) == 0) : 1'b0;
         aw = w ? 4'h5 : 4'h7;
         rw = w ? 8'h25 : 8'h27;
         vecs.push_back(mk(1,0,4'h7,8'h00, 1,0,4'h5,8'h00,
                           w ? 6'b010000 : 6'b100000, pa, pd, pr));
         vecs.push_back(mk(1,0,4'h7,8'h00, 1,0,4'h5,8'h00,
                           w ? 6'b010010 : 6'b100010, aw, 8'h00, pr));
         vecs.push_back(mk(1,0,4'h7,8'h00, 1,0,4'h5,8'h00,
                           w ? 6'b010100 : 6'b101000, aw, 8'h00, rw));
         pa = aw; pd = 8'h00; pr = rw;
      end
      vecs.push_back(mk(0,0,4'h7,8'h00, 0,0,4'h5,8'h00, 6'b000000, pa, pd, pr));

      // ---- reset state ----
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_ctl", {26'd0, ctl_now()}, 32'd0);
      check("reset_maddr", {28'd0, bus.mem_addr}, 32'd0);
      check("reset_mwdata", {24'd0, bus.mem_wdata}, 32'd0);
      check("reset_rdata", {24'd0, bus.rdata}, 32'd0);
      next_cycle();
      reset = 1'b0;

      // ---- table ----
      for (int i = 0; i < vecs.size(); i++) begin
         apply(vecs[i]);
         @(negedge clk);
         check($sformatf("v%0d_ctl", i), {26'd0, ctl_now()}, {26'd0, vecs[i].ctl});
         check($sformatf("v%0d_maddr", i), {28'd0, bus.mem_addr}, {28'd0, vecs[i].maddr});
         check($sformatf("v%0d_mwdata", i), {24'd0, bus.mem_wdata}, {24'd0, vecs[i].mwdata});
         check($sformatf("v%0d_rdata", i), {24'd0, bus.rdata}, {24'd0, vecs[i].rdata});
         next_cycle();
      end

      // ---- reset pulsed during the ACCESS cycle of a write to addr 5 ----
      v = mk(1,1,4'h5,8'h99, 0,0,4'h0,8'h00, 6'b0, 4'h0, 8'h00, 8'h00);
      apply(v);
      @(negedge clk);
      check("rst_seq_grant", {26'd0, ctl_now()}, {26'd0, 6'b100000});
      next_cycle();
      check("rst_seq_access", {26'd0, ctl_now()}, {26'd0, 6'b100001});
      check("rst_seq_maddr", {28'd0, bus.mem_addr}, 32'h5);
      #2;
      reset = 1'b1;
      bus.req0 = 1'b0;
      #1;
      check("rst_async_ctl", {26'd0, ctl_now()}, 32'd0);
      check("rst_async_maddr", {28'd0, bus.mem_addr}, 32'd0);
      check("rst_async_mwdata", {24'd0, bus.mem_wdata}, 32'd0);
      check("rst_async_rdata", {24'd0, bus.rdata}, 32'd0);
      next_cycle();
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("rst_no_done%0d", i), {26'd0, ctl_now()}, 32'd0);
         next_cycle();
      end

      // ---- after reset a tie goes to requester 0 ----
      apply(mk(1,0,4'hA,8'h00, 1,0,4'h5,8'h00, 6'b0, 4'h0, 8'h00, 8'h00));
      @(negedge clk);
      check("prio_grant", {26'd0, ctl_now()}, {26'd0, 6'b100000});
      next_cycle();
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      @(negedge clk);
      check("prio_access", {26'd0, ctl_now()}, {26'd0, 6'b100010});
      check("prio_maddr", {28'd0, bus.mem_addr}, 32'hA);
      next_cycle();
      @(negedge clk);
      check("prio_done", {26'd0, ctl_now()}, {26'd0, 6'b101000});
      check("prio_rdata", {24'd0, bus.rdata}, 32'h02);
      next_cycle();
      @(negedge clk);
      check("prio_idle", {26'd0, ctl_now()}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
